// File: rtl/cluster_ldst_sequencer.sv
// Splits one vector load/store into contiguous per-cluster chunks and issues them one at a time.
// Tracks per-cluster completion and pulses a single response once all issued chunks finish.
module cluster_ldst_sequencer #(
  parameter int unsigned NrClusters = 4,
  parameter int unsigned VlWidth    = 16,
  parameter int unsigned AddrWidth  = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [AddrWidth-1:0]  req_addr_i,
  input  logic [VlWidth-1:0]    req_vl_i,
  input  logic [1:0]            req_vsew_i,
  input  logic                  req_store_i,
  output logic [NrClusters-1:0] cl_valid_o,
  input  logic [NrClusters-1:0] cl_ready_i,
  output logic [AddrWidth-1:0]  cl_addr_o,
  output logic [VlWidth-1:0]    cl_vl_o,
  output logic                  cl_store_o,
  input  logic [NrClusters-1:0] cl_done_i,
  output logic                  resp_valid_o,
  output logic                  busy_o
);

  localparam int unsigned IdxW = $clog2(NrClusters);
  localparam int unsigned OffW = VlWidth + IdxW;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                state_q;
  logic [AddrWidth-1:0]  addr_q;
  logic [VlWidth-1:0]    vl_q;
  logic [1:0]            vsew_q;
  logic                  store_q;
  logic [VlWidth:0]      chunk_q;
  logic [IdxW-1:0]       idx_q;
  logic [NrClusters-1:0] pending_q, pending_d;

  logic [VlWidth:0]      req_chunk;
  logic [OffW-1:0]       off, vl_ext, chunk_ext, remain;
  logic [VlWidth-1:0]    cur_vl;
  logic [AddrWidth-1:0]  cur_addr;
  logic [NrClusters-1:0] idx_onehot;
  logic                  issue_active, handshake, advance, last_idx;

  // Ceiling divide by the cluster count; one extra bit keeps vl near 2^VlWidth from overflowing.
  assign req_chunk = ({1'b0, req_vl_i} + (VlWidth+1)'(NrClusters - 1)) >> IdxW;

  assign off       = OffW'(idx_q) * OffW'(chunk_q);
  assign vl_ext    = OffW'(vl_q);
  assign chunk_ext = OffW'(chunk_q);
  assign remain    = vl_ext - off;

  always_comb begin
    cur_vl = '0;
    if (off < vl_ext) begin
      cur_vl = (chunk_ext < remain) ? VlWidth'(chunk_ext) : VlWidth'(remain);
    end
  end

  assign cur_addr = addr_q + (AddrWidth'(off) << vsew_q);

  always_comb begin
    idx_onehot        = '0;
    idx_onehot[idx_q] = 1'b1;
  end

  assign issue_active = (state_q == StIssue) && (cur_vl != '0);
  assign handshake    = issue_active && cl_ready_i[idx_q];
  assign advance      = (state_q == StIssue) && ((cur_vl == '0) || cl_ready_i[idx_q]);
  assign last_idx     = (idx_q == IdxW'(NrClusters - 1));

  // A done coinciding with the issue handshake of the same cluster belongs to no chunk of ours.
  always_comb begin
    pending_d = pending_q & ~cl_done_i;
    if (handshake) begin
      pending_d[idx_q] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      vl_q      <= '0;
      vsew_q    <= '0;
      store_q   <= 1'b0;
      chunk_q   <= '0;
      idx_q     <= '0;
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            addr_q  <= req_addr_i;
            vl_q    <= req_vl_i;
            vsew_q  <= req_vsew_i;
            store_q <= req_store_i;
            chunk_q <= req_chunk;
            idx_q   <= '0;
            state_q <= (req_vl_i == '0) ? StResp : StIssue;
          end
        end
        StIssue: begin
          if (advance) begin
            idx_q <= idx_q + IdxW'(1);
            if (last_idx) begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if ((pending_q & ~cl_done_i) == '0) begin
            state_q <= StResp;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o  = (state_q == StIdle);
  assign resp_valid_o = (state_q == StResp);
  assign busy_o       = (state_q != StIdle);
  assign cl_valid_o   = issue_active ? idx_onehot : '0;
  assign cl_addr_o    = issue_active ? cur_addr : '0;
  assign cl_vl_o      = issue_active ? cur_vl : '0;
  assign cl_store_o   = issue_active && store_q;

endmodule

// File: doc/cluster_ldst_sequencer.md
# cluster_ldst_sequencer

Sequences one vector load/store at a time across the `NrClusters` Ara clusters. It takes a decoded memory request (base address, `vl`, `vsew`, direction) from the dispatch side and splits the `vl` elements into contiguous per-cluster chunks. It issues the chunks to the clusters one at a time over a shared one-hot valid/ready channel, tracks per-cluster completion, and pulses a single response once every issued chunk has finished. It sits between the global vl/vtype decode and the per-cluster VLSUs.

## Interface
- `NrClusters`, default 4: number of clusters. Must be a power of 2 and ≥ 2.
- `VlWidth`, default 16: width of `vl` fields.
- `AddrWidth`, default 64: address width.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request accepted when `req_valid_i & req_ready_o`.
- `req_addr_i`  in  AddrWidth  base byte address.
- `req_vl_i`  in  VlWidth  total element count.
- `req_vsew_i`  in  2  element size is log2 bytes (0 = 8b … 3 = 64b).
- `req_store_i`  in  1  1 = store, 0 = load.
- `cl_valid_o`  out  NrClusters  one-hot issue valid, bit k addresses cluster k.
- `cl_ready_i`  in  NrClusters  per-cluster issue ready.
- `cl_addr_o`  out  AddrWidth  chunk start address.
- `cl_vl_o`  out  VlWidth  chunk element count.
- `cl_store_o`  out  1  direction of the chunk.
- `cl_done_i`  in  NrClusters  per-cluster single-cycle completion pulse.
- `resp_valid_o`  out  1  single-cycle pulse: whole request completed.
- `busy_o`  out  1  high in every state except IDLE.

## Operation
- Registered request fields, latched on acceptance:
  - `addr_q`, `vl_q`, `vsew_q`, `store_q`.
  - `chunk_q = (vl + NrClusters-1) >> log2(NrClusters)`, computed at VlWidth+1 bits, no overflow.
- Chunk for cluster k:
  - `off_k = k*chunk_q`, computed at VlWidth+log2(NrClusters) bits.
  - `vl_k = off_k >= vl_q ? 0 : min(chunk_q, vl_q-off_k)`.
  - `addr_k = addr_q + (off_k << vsew_q)`, modulo 2^AddrWidth (wraps silently).
- Other state:
  - `idx_q`: issue index, log2(NrClusters) bits.
  - `pending_q`: NrClusters bits, one per cluster.
- IDLE:
  - `req_ready_o = 1`.
  - On acceptance, latch the request and clear `idx_q`.
  - If `req_vl_i == 0`, go to RESP; otherwise go to ISSUE.
- ISSUE, for cluster `idx_q`:
  - If `vl_k == 0`: no valid is driven; the index advances in one cycle.
  - Else: drive `cl_valid_o = 1<<idx_q` with `cl_addr_o = addr_k`, `cl_vl_o = vl_k`, `cl_store_o = store_q`.
  - Hold valid and payload stable until `cl_ready_i[idx_q]`. On the handshake, set `pending_q[idx_q]` and advance.
  - After handling `idx_q == NrClusters-1`, go to WAIT.
- WAIT: go to RESP in the cycle where `(pending_q & ~cl_done_i) == 0`.
- RESP: `resp_valid_o = 1` for exactly one cycle, then return to IDLE.
- Done handling, in every state:
  - `cl_done_i[k]` clears `pending_q[k]`.
  - A done on a bit that is not pending is ignored.
  - A done in the same cycle as cluster k's issue handshake is ignored; the new pending bit is set.
- Outputs decoded from state: `req_ready_o` only in IDLE, `cl_valid_o` only in ISSUE, `resp_valid_o` only in RESP.
- When `cl_valid_o == 0`, `cl_addr_o`, `cl_vl_o` and `cl_store_o` are driven 0.
- Reset (asserted at any time, including mid-request):
  - State goes to IDLE and `pending_q` clears.
  - In-flight work is abandoned and no response is produced.
  - Outputs after reset: `req_ready_o = 1`, `cl_valid_o = 0`, `resp_valid_o = 0`, `busy_o = 0`, payload 0.

## Timing
- Request accepted in cycle T. First chunk valid is driven in T+1.
- With clusters always ready, cluster k is issued in T+1+k (skipped clusters also take one cycle each).
- WAIT is entered the cycle after the last index is handled.
- `resp_valid_o` is high in the cycle after the cycle in which the final pending bit is cleared by `cl_done_i`.
- `req_vl_i == 0`: `resp_valid_o` is high in T+1.
- The next request can be accepted in the cycle after RESP. There is no back-to-back overlap.
- No combinational path from `cl_ready_i` or `cl_done_i` to `cl_valid_o` or the payload. State only changes at the clock edge.

## Test plan
- Accept `addr = 0x1000`, `vl = 10`, `vsew = 2`, load, all ready, NrClusters = 4 -> issues in T+1..T+4:
  - cluster 0: vl 3 @ 0x1000
  - cluster 1: vl 3 @ 0x100C
  - cluster 2: vl 3 @ 0x1018
  - cluster 3: vl 1 @ 0x1024
  - Dones in order 3, 0, 2, 1 at cycles D..D+3 -> single `resp_valid_o` at D+4.
- `vl = 2`, `vsew = 3`, `addr = 0xFFFF_FFFF_FFFF_FFF8`, store -> cluster 0: vl 1 @ 0xFFFF_FFFF_FFFF_FFF8; cluster 1: vl 1 @ 0x0 (wrap). Clusters 2 and 3 are never valid. Response follows both dones.
- `cl_ready_i[1] = 0` for 5 cycles -> `cl_valid_o = 0b0010` held with stable payload for 6 cycles. Cluster 2 is issued the cycle after the handshake.
- `vl = 0` -> `resp_valid_o` in T+1, `cl_valid_o` never set, `busy_o` high for exactly one cycle.
- Spurious `cl_done_i[2]` in WAIT with bit 2 not pending, and `cl_done_i[0]` in the same cycle as cluster 0's handshake -> both ignored. The response waits for the real dones.
- Assert `rst_i` during WAIT with 2 chunks pending -> immediately IDLE, `busy_o = 0`, no `resp_valid_o`. Later dones are ignored, and a new request issues normally.
